mem_access_unit: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs (control flags, ALU result, store data, zero flag).
- Turns MemRead/MemWrite into a req/ack transaction on a variable-latency data-memory port.
- Stalls the upstream pipeline while the transaction is outstanding, captures read data for the MEM/WB register, and produces the branch-taken select.

---
 rtl/mem_access_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_access_unit : MEM-stage req/ack data-memory access with stall and branch select
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  MEM_Flag,
  input  logic        MEM_ZeroFlag,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_ReaddData2,
  output logic        MEM_Stall,
  output logic        MEM_PCSrc,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_ReadValid,
  output logic        MEM_Misalign,
  output logic        MEM_TimeoutErr,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              misalign_q, misalign_d;
  logic              terr_q, terr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic mem_read, mem_write, branch, access, aligned, stall;
  logic unused_flags;

  assign mem_read     = MEM_Flag[3];
  assign mem_write    = MEM_Flag[2];
  assign branch       = MEM_Flag[1];
  assign access       = mem_read | mem_write;
  assign aligned      = (MEM_ALUResult[1:0] == 2'b00);
  assign unused_flags = MEM_Flag[4] ^ MEM_Flag[0];

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    misalign_d = 1'b0;
    terr_d     = terr_q;
    cnt_d      = cnt_q;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (aligned) begin
            stall   = 1'b1;
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = mem_write;  // write wins when both flags are set
            addr_d  = MEM_ALUResult;
            wdata_d = MEM_ReaddData2;
            cnt_d   = '0;
          end else begin
            misalign_d = 1'b1;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            rdata_d  = dmem_rdata;
            rvalid_d = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_M1) begin
          req_d   = 1'b0;
          terr_d  = 1'b1;
          state_d = DONE;
          if (!we_q) begin
            rdata_d  = '0;
            rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        // Pipeline advances this cycle; the instruction still present is not re-issued.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      misalign_q <= 1'b0;
      terr_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      misalign_q <= misalign_d;
      terr_q     <= terr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign MEM_Stall      = stall & ~rst;
  assign MEM_PCSrc      = branch & MEM_ZeroFlag & ~rst;
  assign MEM_ReadData   = rdata_q;
  assign MEM_ReadValid  = rvalid_q;
  assign MEM_Misalign   = misalign_q;
  assign MEM_TimeoutErr = terr_q;
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_wdata     = wdata_q;

endmodule
`default_nettype wire
